// File: rtl/cla_pkg.sv
// Shared types and constants for the sequential carry-lookahead post stage.
package cla_pkg;

    localparam int CLA_GROUP_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } cla_post_state_t;

endpackage

// File: rtl/cla_group_4.sv
// Combinational 4-bit carry-lookahead group: sum bits and group carry-out from g/p/cin.
// Zero latency; no handshake of its own.
module cla_group_4
    import cla_pkg::*;
(
    input  logic [CLA_GROUP_W-1:0] i_g,
    input  logic [CLA_GROUP_W-1:0] i_p,
    input  logic                   i_c,
    output logic [CLA_GROUP_W-1:0] o_s,
    output logic                   o_c
);

    logic [CLA_GROUP_W-1:0] w_h;
    logic [CLA_GROUP_W:0]   w_c;

    // p = a|b and g = a&b, so p & ~g recovers a^b
    assign w_h = i_p & ~i_g;

    // Flattened lookahead: every carry depends only on g, p and the group carry-in
    assign w_c[0] = i_c;
    assign w_c[1] = i_g[0] | (i_p[0] & i_c);
    assign w_c[2] = i_g[1] | (i_p[1] & i_g[0]) | (i_p[1] & i_p[0] & i_c);
    assign w_c[3] = i_g[2] | (i_p[2] & i_g[1]) | (i_p[2] & i_p[1] & i_g[0])
                  | (i_p[2] & i_p[1] & i_p[0] & i_c);
    assign w_c[4] = i_g[3] | (i_p[3] & i_g[2]) | (i_p[3] & i_p[2] & i_g[1])
                  | (i_p[3] & i_p[2] & i_p[1] & i_g[0])
                  | (i_p[3] & i_p[2] & i_p[1] & i_p[0] & i_c);

    assign o_s = w_h ^ w_c[CLA_GROUP_W-1:0];
    assign o_c = w_c[CLA_GROUP_W];

endmodule

// File: rtl/cla_post_seq.sv
// Sequential CLA post stage: resolves one 4-bit group per clock; CLA_POST_OVF_EN adds o_ovf.
// Latency: o_valid N_GROUPS edges after accept; initiation interval N_GROUPS+2.
// Backpressure: DONE holds result stable until i_ready; o_ready only in IDLE.
module cla_post_seq
    import cla_pkg::*;
#(
    parameter int N_GROUPS = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [CLA_GROUP_W*N_GROUPS-1:0] i_g,
    input  logic [CLA_GROUP_W*N_GROUPS-1:0] i_p,
    input  logic                          i_c,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic [CLA_GROUP_W*N_GROUPS-1:0] o_s,
    output logic                          o_c,
`ifdef CLA_POST_OVF_EN
    output logic                          o_ovf,
`endif
    output logic                          o_valid,
    input  logic                          i_ready
);

    localparam int W  = CLA_GROUP_W * N_GROUPS;
    localparam int CW = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;

    cla_post_state_t r_state, w_state_nxt;

    logic [W-1:0]           r_g;
    logic [W-1:0]           r_p;
    logic [W-1:0]           r_s;
    logic                   r_carry;
    logic [CW-1:0]          r_cnt;

    logic [CLA_GROUP_W-1:0] w_grp_g;
    logic [CLA_GROUP_W-1:0] w_grp_p;
    logic [CLA_GROUP_W-1:0] w_grp_s;
    logic                   w_grp_c;
    logic [W-1:0]           w_s_nxt;
    logic                   w_last;
    logic                   w_accept;

    assign w_accept = i_valid && (r_state == IDLE);
    assign w_last   = (r_cnt == CW'(N_GROUPS - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_valid) w_state_nxt = CALC;
            CALC:    if (w_last) w_state_nxt = DONE;
            DONE:    if (i_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Single lookahead group shared across the word, selected by the counter
    always_comb begin
        w_grp_g = '0;
        w_grp_p = '0;
        for (int k = 0; k < N_GROUPS; k++) begin
            if (r_cnt == CW'(k)) begin
                w_grp_g = r_g[k*CLA_GROUP_W +: CLA_GROUP_W];
                w_grp_p = r_p[k*CLA_GROUP_W +: CLA_GROUP_W];
            end
        end
    end

    always_comb begin
        w_s_nxt = r_s;
        for (int k = 0; k < N_GROUPS; k++) begin
            if (r_cnt == CW'(k)) begin
                w_s_nxt[k*CLA_GROUP_W +: CLA_GROUP_W] = w_grp_s;
            end
        end
    end

    cla_group_4 u_group (
        .i_g (w_grp_g),
        .i_p (w_grp_p),
        .i_c (r_carry),
        .o_s (w_grp_s),
        .o_c (w_grp_c)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_g     <= '0;
            r_p     <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_g     <= i_g;
            r_p     <= i_p;
            r_s     <= '0;
            r_carry <= i_c;
            r_cnt   <= '0;
        end else if (r_state == CALC) begin
            r_s     <= w_s_nxt;
            r_carry <= w_grp_c;
            r_cnt   <= r_cnt + CW'(1);
        end
    end

`ifdef CLA_POST_OVF_EN
    logic r_ovf;
    logic w_c_msb_in;

    // Carry into the MSB recovered from its sum bit and half-sum
    assign w_c_msb_in = w_grp_s[CLA_GROUP_W-1]
                      ^ (w_grp_p[CLA_GROUP_W-1] & ~w_grp_g[CLA_GROUP_W-1]);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= 1'b0;
        end else if ((r_state == CALC) && w_last) begin
            r_ovf <= w_grp_c ^ w_c_msb_in;
        end
    end

    assign o_ovf = r_ovf;
`endif

    assign o_ready = (r_state == IDLE);
    assign o_valid = (r_state == DONE);
    assign o_s     = r_s;
    assign o_c     = r_carry;

endmodule
